// File: rtl/machine_pkg.sv
// Shared types and constants for the seven-segment digit scanner.
package machine_pkg;

  localparam int NDIGITS = 4;
  localparam int NIB_W   = 4;
  localparam int VAL_W   = NDIGITS * NIB_W;
  localparam int IDX_W   = $clog2(NDIGITS);

  localparam logic [NDIGITS-1:0] AN_OFF = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } slot_state_e;

  function automatic logic [NIB_W-1:0] nibble(input logic [VAL_W-1:0] v,
                                              input logic [IDX_W-1:0] k);
    return v[k*NIB_W +: NIB_W];
  endfunction

  // Active-low one-hot anode pattern for digit k.
  function automatic logic [NDIGITS-1:0] anode_on(input logic [IDX_W-1:0] k);
    return ~(NDIGITS'(1) << k);
  endfunction

endpackage

// File: rtl/machine_scan_tick.sv
// Digit-slot timebase: counts DIV cycles per slot, flags the last cycle of
// the slot and the leading GUARD cycles that must stay blanked.
module machine_scan_tick
  import machine_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic in_guard
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    slot_end = (cnt_q == CNT_W'(DIV - 1));
    // Signed int compare so GUARD=0 simply never blanks.
    in_guard = (int'(cnt_q) < GUARD);
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/machine_digit_scan.sv
// Four-digit multiplexed display scanner with pending/shadow value buffering
// and guard blanking. Define MACHINE_SCAN_LZB_EN for leading-zero blanking.
module machine_digit_scan
  import machine_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VAL_W-1:0]   value,
  input  logic               load,
  input  logic [NDIGITS-1:0] dp_mask,
  output logic [NIB_W-1:0]   ds,
  output logic [NDIGITS-1:0] an,
  output logic               dp_n,
  output logic               frame
);

  logic        slot_end;
  logic        in_guard;
  slot_state_e slot_state;
  logic        suppress;

  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [VAL_W-1:0]   pend_v_q,  pend_v_d;
  logic [NDIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VAL_W-1:0]   shad_v_q,  shad_v_d;
  logic [NDIGITS-1:0] shad_dp_q, shad_dp_d;
  logic [NIB_W-1:0]   ds_q,      ds_d;
  logic [NDIGITS-1:0] an_q,      an_d;
  logic               dp_n_q,    dp_n_d;
  logic               frame_q,   frame_d;

  machine_scan_tick #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .slot_end (slot_end),
    .in_guard (in_guard)
  );

  assign slot_state = in_guard ? BLANK : DRIVE;

`ifdef MACHINE_SCAN_LZB_EN
  // Digit k>0 is dark when it and every more significant nibble are zero.
  always_comb begin
    suppress = (idx_q != '0) && ((shad_v_q >> (NIB_W * idx_q)) == '0);
  end
`else
  assign suppress = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    idx_d     = idx_q;
    pend_v_d  = pend_v_q;
    pend_dp_d = pend_dp_q;
    shad_v_d  = shad_v_q;
    shad_dp_d = shad_dp_q;
    frame_d   = 1'b0;
    ds_d      = nibble(shad_v_q, idx_q);
    an_d      = AN_OFF;
    dp_n_d    = 1'b1;

    if (load) begin
      pend_v_d  = value;
      pend_dp_d = dp_mask;
    end

    if (slot_end) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == IDX_W'(NDIGITS - 1)) begin
        // A load on the wrap edge bypasses the pending register.
        shad_v_d  = load ? value   : pend_v_q;
        shad_dp_d = load ? dp_mask : pend_dp_q;
        frame_d   = 1'b1;
      end
    end

    if (slot_state == DRIVE && !suppress) begin
      an_d   = anode_on(idx_q);
      dp_n_d = ~shad_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      pend_v_q  <= '0;
      pend_dp_q <= '0;
      shad_v_q  <= '0;
      shad_dp_q <= '0;
      ds_q      <= '0;
      an_q      <= AN_OFF;
      dp_n_q    <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pend_v_q  <= pend_v_d;
      pend_dp_q <= pend_dp_d;
      shad_v_q  <= shad_v_d;
      shad_dp_q <= shad_dp_d;
      ds_q      <= ds_d;
      an_q      <= an_d;
      dp_n_q    <= dp_n_d;
      frame_q   <= frame_d;
    end
  end

  assign ds    = ds_q;
  assign an    = an_q;
  assign dp_n  = dp_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_machine_digit_scan.sv
// Directed bench for machine_digit_scan (DIV=8, GUARD=2) with a cycle
// scoreboard plus per-frame observations of anode/digit behaviour.
module tb_machine_digit_scan;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
`ifdef MACHINE_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic [3:0]  ds;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame;

  machine_digit_scan #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .load    (load),
    .dp_mask (dp_mask),
    .ds      (ds),
    .an      (an),
    .dp_n    (dp_n),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [3:0] ds;
    logic [3:0] an;
    logic       dp_n;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  // Reference state: what the display should hold before the next edge.
  int          m_cnt, m_idx;
  logic [15:0] m_pend_v, m_shad_v;
  logic [3:0]  m_pend_dp, m_shad_dp;

  // Per-window observations.
  int         n;
  int         frame_times[$];
  logic [3:0] ds_seen[4];
  logic       dpn_seen[4];
  int         an_low_cnt[4];
  int         dp_low_cycles;
  int         first_low_n;
  logic [3:0] ds_or;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit   drive, sup;
    drive   = (m_cnt >= GUARD);
    sup     = LZB && (m_idx != 0) && ((m_shad_v >> (4 * m_idx)) == 16'h0);
    e.ds    = m_shad_v[4*m_idx +: 4];
    e.an    = (drive && !sup) ? ~(4'b0001 << m_idx) : 4'hF;
    e.dp_n  = (drive && !sup) ? ~m_shad_dp[m_idx] : 1'b1;
    e.frame = (m_cnt == DIV - 1) && (m_idx == 3);
    return e;
  endfunction

  task automatic model_edge();
    if (m_cnt == DIV - 1) begin
      if (m_idx == 3) begin
        m_shad_v  = load ? value   : m_pend_v;
        m_shad_dp = load ? dp_mask : m_pend_dp;
      end
      m_idx = (m_idx + 1) % 4;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    if (load) begin
      m_pend_v  = value;
      m_pend_dp = dp_mask;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_pend_v = '0; m_shad_v = '0; m_pend_dp = '0; m_shad_dp = '0;
    n = 0;
    frame_times.delete();
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 4; k++) begin
      ds_seen[k]    = 4'hx;
      dpn_seen[k]   = 1'bx;
      an_low_cnt[k] = 0;
    end
    dp_low_cycles = 0;
    first_low_n   = -1;
    ds_or         = 4'h0;
  endtask

  task automatic step();
    exp_t o;
    logic [3:0] an_k;
    sb.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
    n++;
    o = sb.pop_front();
    check($sformatf("ds@%0d", n),    16'(ds),    16'(o.ds));
    check($sformatf("an@%0d", n),    16'(an),    16'(o.an));
    check($sformatf("dp_n@%0d", n),  16'(dp_n),  16'(o.dp_n));
    check($sformatf("frame@%0d", n), 16'(frame), 16'(o.frame));
    if (frame === 1'b1) frame_times.push_back(n);
    if (dp_n === 1'b0) dp_low_cycles++;
    ds_or = ds_or | ds;
    for (int k = 0; k < 4; k++) begin
      an_k = ~(4'b0001 << k);
      if (an === an_k) begin
        an_low_cnt[k]++;
        ds_seen[k]  = ds;
        dpn_seen[k] = dp_n;
        if (first_low_n < 0) first_low_n = n;
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic to_state(input int c, input int i);
    for (int k = 0; k < 64 && !(m_cnt == c && m_idx == i); k++) step();
  endtask

  task automatic check_full_frame(input string tag, input logic [3:0] lz_mask);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_an_low%0d", tag, k), 16'(an_low_cnt[k]),
            16'((LZB && lz_mask[k]) ? 0 : DIV - GUARD));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; load = 1'b0; value = '0; dp_mask = '0;
    model_reset();
    clear_seen();

    // Asynchronous reset, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_an", 16'(an), 16'hF);
    check("rst_ds", 16'(ds), 16'h0);
    check("rst_dp_n", 16'(dp_n), 16'h1);
    check("rst_frame", 16'(frame), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Idle scan of an all-zero value.
    clear_seen();
    run(32);
    check_full_frame("idle", 4'b1110);
    check("idle_ds0", 16'(ds_seen[0]), 16'h0);
    check("idle_first_low", 16'(first_low_n), 16'(GUARD + 1));
    check("frame_first", 16'(frame_times.size() > 0 ? frame_times[0] : -1), 16'd32);
    run(8);

    // Mid-frame load must not tear the current frame.
    value = 16'h12A4; dp_mask = 4'b0100; load = 1'b1;
    clear_seen();
    step();
    load = 1'b0; value = '0; dp_mask = '0;
    to_state(0, 0);
    check("midload_no_tear", 16'(ds_or), 16'h0);
    check("frame_period", 16'(frame_times.size() > 1 ? frame_times[1] - frame_times[0] : -1), 16'd32);
    clear_seen();
    run(32);
    check_full_frame("val12a4", 4'b0000);
    check("val12a4_d0", 16'(ds_seen[0]), 16'h4);
    check("val12a4_d1", 16'(ds_seen[1]), 16'hA);
    check("val12a4_d2", 16'(ds_seen[2]), 16'h2);
    check("val12a4_d3", 16'(ds_seen[3]), 16'h1);
    check("dp_d2", 16'(dpn_seen[2]), 16'h0);
    check("dp_d0", 16'(dpn_seen[0]), 16'h1);
    check("dp_d3", 16'(dpn_seen[3]), 16'h1);
    check("dp_low_cycles", 16'(dp_low_cycles), 16'(DIV - GUARD));

    // Load on the exact wrap edge shows in the very next frame.
    to_state(DIV - 1, 3);
    value = 16'h00F0; load = 1'b1;
    step();
    load = 1'b0; value = '0;
    clear_seen();
    run(32);
    check_full_frame("wrapload", 4'b1100);
    check("wrapload_d0", 16'(ds_seen[0]), 16'h0);
    check("wrapload_d1", 16'(ds_seen[1]), 16'hF);

    // Leading-zero case.
    value = 16'h0030; load = 1'b1;
    step();
    load = 1'b0; value = '0;
    to_state(0, 0);
    clear_seen();
    run(32);
    check_full_frame("lz0030", 4'b1100);
    check("lz0030_d1", 16'(ds_seen[1]), 16'h3);
    check("lz0030_d0", 16'(ds_seen[0]), 16'h0);

    // Back-to-back loads within one frame: the last one wins.
    run(5);
    value = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    run(2);
    value = 16'h2222; load = 1'b1;
    step();
    load = 1'b0; value = '0;
    to_state(0, 0);
    clear_seen();
    run(32);
    check_full_frame("last_wins", 4'b0000);
    for (int k = 0; k < 4; k++)
      check($sformatf("last_wins_d%0d", k), 16'(ds_seen[k]), 16'h2);
    check("last_wins_or", 16'(ds_or), 16'h2);

    // Reset pulse while digit 2 is driving.
    to_state(4, 2);
    step();
    check("pre_rst_an", 16'(an), 16'hB);
    #3 rst = 1'b1;
    #1;
    check("midrst_an", 16'(an), 16'hF);
    check("midrst_ds", 16'(ds), 16'h0);
    check("midrst_dp_n", 16'(dp_n), 16'h1);
    @(posedge clk);
    #1;
    check("midrst_hold_an", 16'(an), 16'hF);
    #2 rst = 1'b0;
    model_reset();
    clear_seen();
    run(32);
    check("post_rst_first_low", 16'(first_low_n), 16'(GUARD + 1));
    check("post_rst_shadow", 16'(ds_or), 16'h0);
    check_full_frame("post_rst", 4'b1110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
